// File: rtl/bsg_manycore_axil_word_packer.sv
// Packs host-side AXI-Lite words into manycore fifo packets and unpacks fifo packets
// back into host words, with flush (clear) and completed-packet counters.
module bsg_manycore_axil_word_packer #(
    parameter int fifo_width_p      = 128,
    parameter int axil_data_width_p = 32,
    localparam int els_lp           = fifo_width_p / axil_data_width_p,
    localparam int lg_els_lp        = $clog2(els_lp)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,

    input  logic                         tx_v_i,
    input  logic [axil_data_width_p-1:0] tx_data_i,
    output logic                         tx_ready_o,

    output logic                         tx_fifo_v_o,
    output logic [fifo_width_p-1:0]      tx_fifo_data_o,
    input  logic                         tx_fifo_ready_i,

    input  logic                         rx_fifo_v_i,
    input  logic [fifo_width_p-1:0]      rx_fifo_data_i,
    output logic                         rx_fifo_ready_o,

    output logic                         rx_v_o,
    output logic [axil_data_width_p-1:0] rx_data_o,
    input  logic                         rx_ready_i,

    output logic [lg_els_lp-1:0]         tx_word_cnt_o,
    output logic [lg_els_lp-1:0]         rx_word_idx_o,
    output logic [31:0]                  tx_pkt_count_o,
    output logic [31:0]                  rx_pkt_count_o
);

    localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_lp - 1);
    localparam int asm_width_lp = fifo_width_p - axil_data_width_p;

    logic [lg_els_lp-1:0]    tx_cnt_r;
    logic [lg_els_lp-1:0]    rx_idx_r;
    logic [asm_width_lp-1:0] asm_r;
    logic [fifo_width_p-1:0] pkt_r;
    logic                    pkt_valid_r;
    logic [31:0]             tx_pkt_count_r;
    logic [31:0]             rx_pkt_count_r;

    logic flush;
    logic tx_last;
    logic tx_accept;
    logic tx_fifo_hs;
    logic rx_hs;
    logic rx_fifo_hs;

    // Reset behaves as a clear for all handshake outputs and in-flight state.
    assign flush      = clear_i | reset_i;
    assign tx_last    = (tx_cnt_r == last_idx_lp);
    assign tx_ready_o = ~flush & (~tx_last | ~pkt_valid_r | tx_fifo_ready_i);
    assign tx_accept  = tx_v_i & tx_ready_o;

    assign tx_fifo_v_o    = pkt_valid_r & ~flush;
    assign tx_fifo_data_o = pkt_r;
    assign tx_fifo_hs     = tx_fifo_v_o & tx_fifo_ready_i;

    assign rx_v_o          = rx_fifo_v_i & ~flush;
    assign rx_hs           = rx_v_o & rx_ready_i;
    assign rx_fifo_ready_o = rx_ready_i & rx_fifo_v_i & ~flush & (rx_idx_r == last_idx_lp);
    assign rx_fifo_hs      = rx_fifo_v_i & rx_fifo_ready_o;

    assign tx_word_cnt_o  = tx_cnt_r;
    assign rx_word_idx_o  = rx_idx_r;
    assign tx_pkt_count_o = tx_pkt_count_r;
    assign rx_pkt_count_o = rx_pkt_count_r;

    always_comb begin
        rx_data_o = '0;
        for (int k = 0; k < els_lp; k++) begin
            if (rx_idx_r == lg_els_lp'(k)) begin
                rx_data_o = rx_fifo_data_i[k*axil_data_width_p +: axil_data_width_p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            tx_cnt_r    <= '0;
            pkt_valid_r <= 1'b0;
            rx_idx_r    <= '0;
        end else begin
            if (tx_accept) begin
                tx_cnt_r <= tx_last ? '0 : tx_cnt_r + 1'b1;
            end
            // A last-word accept while a packet drains keeps the flag set for the new packet.
            if (tx_accept & tx_last) begin
                pkt_valid_r <= 1'b1;
            end else if (tx_fifo_hs) begin
                pkt_valid_r <= 1'b0;
            end
            if (rx_hs) begin
                rx_idx_r <= rx_idx_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_accept) begin
            if (tx_last) begin
                pkt_r <= {tx_data_i, asm_r};
            end else begin
                for (int k = 0; k < els_lp - 1; k++) begin
                    if (tx_cnt_r == lg_els_lp'(k)) begin
                        asm_r[k*axil_data_width_p +: axil_data_width_p] <= tx_data_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_pkt_count_r <= '0;
            rx_pkt_count_r <= '0;
        end else begin
            if (tx_fifo_hs) begin
                tx_pkt_count_r <= tx_pkt_count_r + 32'd1;
            end
            if (rx_fifo_hs) begin
                rx_pkt_count_r <= rx_pkt_count_r + 32'd1;
            end
        end
    end

endmodule
